// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-controller bus; perf counter outputs exist only with PIPE_PERF_CNT_EN.
interface pipeline_hazard_ctrl_if
`ifdef PIPE_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_load, branch_taken, dmem_req, dmem_ready;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall, mem_timeout;
  logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif
  modport master (
    output id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_load, branch_taken, dmem_req, dmem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall, mem_timeout, state_o
`ifdef PIPE_PERF_CNT_EN
    , perf_stall_cyc, perf_flush_cnt, perf_lu_cnt
`endif
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_load, branch_taken, dmem_req, dmem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall, mem_timeout, state_o
`ifdef PIPE_PERF_CNT_EN
    , perf_stall_cyc, perf_flush_cnt, perf_lu_cnt
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: Mealy stall/flush/bubble sequencer for load-use, branch and dmem wait; PIPE_PERF_CNT_EN adds saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int MAX_WAIT     = 16
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W      = 32
`endif
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'b00, LSTALL = 2'b01, MWAIT = 2'b10, ERR = 2'b11} state_t;
  state_t     r_state;
  logic [2:0] r_bcnt;
  logic [7:0] r_wcnt;
  logic       r_timeout;
  logic w_lu, w_miss, w_active, w_enter, w_flush, w_lu_act, w_ls_bub, w_hold, w_bub_stall, w_pc_stall;
  assign w_lu = hz.ex_load & (|hz.ex_rd) &
                ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) | (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
  assign w_miss      = hz.dmem_req & ~hz.dmem_ready;
  assign w_active    = (r_state == RUN) | (r_state == LSTALL);
  assign w_enter     = w_active & w_miss;
  assign w_flush     = w_active & ~w_miss & hz.branch_taken;
  assign w_lu_act    = (r_state == RUN) & ~w_miss & ~hz.branch_taken & w_lu;
  assign w_ls_bub    = (r_state == LSTALL) & ~w_miss & ~hz.branch_taken;
  assign w_hold      = (r_state == ERR) | ((r_state == MWAIT) & ~hz.dmem_ready) | w_enter;
  assign w_bub_stall = w_lu_act | w_ls_bub;
  assign w_pc_stall  = w_hold | w_bub_stall;
  assign hz.pc_stall    = ~rst & w_pc_stall;
  assign hz.ifid_stall  = ~rst & w_pc_stall;
  assign hz.ifid_flush  = ~rst & w_flush;
  assign hz.idex_bubble = ~rst & (w_flush | w_bub_stall);
  assign hz.idex_stall  = ~rst & w_hold;
  assign hz.exmem_stall = ~rst & w_hold;
  assign hz.mem_timeout = ~rst & r_timeout;
  assign hz.state_o     = rst ? 2'b00 : r_state;
  // bubble_cnt stays frozen across a memory wait so the remaining load bubbles resume afterwards
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= RUN;
      r_bcnt    <= '0;
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (w_enter) begin
      r_state <= MWAIT;
      r_wcnt  <= 8'd1;
    end else if (r_state == MWAIT) begin
      if (hz.dmem_ready) begin
        r_wcnt  <= '0;
        r_state <= (r_bcnt != 3'd0) ? LSTALL : RUN;
      end else if (r_wcnt == 8'(MAX_WAIT)) begin
        r_timeout <= 1'b1;
        r_state   <= ERR;
      end else
        r_wcnt <= r_wcnt + 8'd1;
    end else if (w_flush) begin
      r_bcnt  <= '0;
      r_state <= RUN;
    end else if (w_lu_act && LOAD_BUBBLES > 1) begin
      r_bcnt  <= 3'(LOAD_BUBBLES - 1);
      r_state <= LSTALL;
    end else if (w_ls_bub) begin
      r_bcnt <= r_bcnt - 3'd1;
      if (r_bcnt == 3'd1) r_state <= RUN;
    end
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall, r_perf_flush, r_perf_lu;
  always_ff @(posedge clk)
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_lu    <= '0;
    end else begin
      if (w_pc_stall && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 1'b1;
      if (w_flush && !(&r_perf_flush))    r_perf_flush <= r_perf_flush + 1'b1;
      if (w_lu_act && !(&r_perf_lu))      r_perf_lu    <= r_perf_lu + 1'b1;
    end
  assign hz.perf_stall_cyc = r_perf_stall;
  assign hz.perf_flush_cnt = r_perf_flush;
  assign hz.perf_lu_cnt    = r_perf_lu;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table, directed multi-cycle sequences and random run against a reference model.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if ifa ();
  pipeline_hazard_ctrl_if ifb ();
  pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .MAX_WAIT(4)) dut_a (.clk(clk), .rst(rst), .hz(ifa.slave));
  pipeline_hazard_ctrl #(.LOAD_BUBBLES(3), .MAX_WAIT(6)) dut_b (.clk(clk), .rst(rst), .hz(ifb.slave));
  assign ifb.id_rs1 = ifa.id_rs1;
  assign ifb.id_rs2 = ifa.id_rs2;
  assign ifb.ex_rd = ifa.ex_rd;
  assign ifb.id_use_rs1 = ifa.id_use_rs1;
  assign ifb.id_use_rs2 = ifa.id_use_rs2;
  assign ifb.ex_load = ifa.ex_load;
  assign ifb.branch_taken = ifa.branch_taken;
  assign ifb.dmem_req = ifa.dmem_req;
  assign ifb.dmem_ready = ifa.dmem_ready;
  // {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall, mem_timeout, state_o}
  logic [8:0] act_a, act_b;
  assign act_a = {ifa.pc_stall, ifa.ifid_stall, ifa.ifid_flush, ifa.idex_bubble,
                  ifa.idex_stall, ifa.exmem_stall, ifa.mem_timeout, ifa.state_o};
  assign act_b = {ifb.pc_stall, ifb.ifid_stall, ifb.ifid_flush, ifb.idex_bubble,
                  ifb.idex_stall, ifb.exmem_stall, ifb.mem_timeout, ifb.state_o};
  localparam logic [8:0] IDLE = 9'b000000000, LU0 = 9'b110100000, LU1 = 9'b110100001,
                         FL0 = 9'b001100000, FL1 = 9'b001100001, ST0 = 9'b110011000,
                         ST1 = 9'b110011001, ST2 = 9'b110011010, RL2 = 9'b000000010,
                         E3 = 9'b110011111;
  typedef struct {
    logic rst, ld; logic [4:0] rd, rs1; logic u1; logic [4:0] rs2; logic u2;
    logic br, req, rdy; logic [8:0] exp;
  } vec_t;
  int checks = 0, errors = 0;
  int bl[2], wtd[2];
  bit wtg[2], dead[2];
  function automatic vec_t mk(logic r, logic ld, logic [4:0] rd, logic [4:0] rs1, logic u1,
                              logic [4:0] rs2, logic u2, logic br, logic req, logic rdy, logic [8:0] e);
    vec_t v;
    v.rst = r; v.ld = ld; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.br = br; v.req = req; v.rdy = rdy; v.exp = e;
    return v;
  endfunction
  task automatic drive(input vec_t v);
    rst = v.rst;
    ifa.ex_load = v.ld; ifa.ex_rd = v.rd; ifa.id_rs1 = v.rs1; ifa.id_use_rs1 = v.u1;
    ifa.id_rs2 = v.rs2; ifa.id_use_rs2 = v.u2; ifa.branch_taken = v.br;
    ifa.dmem_req = v.req; ifa.dmem_ready = v.rdy;
  endtask
  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input bit use_b, input string nm);
    @(posedge clk);
    #1 drive(v);
    @(negedge clk);
    chk(nm, use_b ? act_b : act_a, v.exp);
  endtask
  // Reference: a waiting flag, bubbles still owed and a dead flag fully describe the controller
  task automatic model(input int k, input vec_t v, output logic [8:0] e);
    int lb, mw;
    logic h, p, f, lu;
    logic [1:0] st;
    lb = (k == 0) ? 1 : 3;
    mw = (k == 0) ? 4 : 6;
    h = 0; p = 0; f = 0;
    if (v.rst) begin
      e = '0; bl[k] = 0; wtd[k] = 0; wtg[k] = 0; dead[k] = 0;
      return;
    end
    st = dead[k] ? 2'd3 : wtg[k] ? 2'd2 : (bl[k] > 0) ? 2'd1 : 2'd0;
    e[2] = dead[k];
    lu = v.ld && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (dead[k]) h = 1;
    else if (wtg[k]) begin
      if (v.rdy) begin wtg[k] = 0; wtd[k] = 0; end
      else begin
        h = 1;
        if (wtd[k] == mw) dead[k] = 1; else wtd[k]++;
      end
    end else if (v.req && !v.rdy) begin h = 1; wtg[k] = 1; wtd[k] = 1; end
    else if (v.br) begin f = 1; bl[k] = 0; end
    else if (bl[k] > 0) begin p = 1; bl[k]--; end
    else if (lu) begin p = 1; bl[k] = lb - 1; end
    e = {h | p, h | p, f, f | p, h, h, e[2], st};
  endtask
  vec_t tbl[13];
  initial begin
    vec_t v;
    logic [8:0] ea, eb;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl[0]  = mk(1, 1, 5, 5, 1, 0, 0, 0, 0, 0, IDLE);
    tbl[1]  = mk(0, 1, 5, 5, 1, 0, 0, 0, 0, 0, LU0);
    tbl[2]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, IDLE);
    tbl[3]  = mk(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, IDLE);
    tbl[4]  = mk(0, 0, 5, 5, 1, 0, 0, 0, 0, 0, IDLE);
    tbl[5]  = mk(0, 1, 7, 1, 1, 7, 1, 0, 0, 0, LU0);
    tbl[6]  = mk(0, 1, 5, 5, 1, 0, 0, 1, 0, 0, FL0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE);
    tbl[8]  = mk(0, 1, 5, 5, 1, 0, 0, 1, 1, 0, ST0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ST2);
    tbl[10] = mk(0, 1, 5, 5, 1, 0, 0, 1, 1, 0, ST2);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RL2);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    for (int i = 0; i < 13; i++) step(tbl[i], 1'b0, $sformatf("vec%0d", i));
    // three load bubbles, then a branch cutting bubbles short, then a wait that freezes them
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE), 1'b1, "lb3_rst");
    step(mk(0, 1, 5, 5, 1, 0, 0, 0, 0, 0, LU0), 1'b1, "lb3_c0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LU1), 1'b1, "lb3_c1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LU1), 1'b1, "lb3_c2");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE), 1'b1, "lb3_c3");
    step(mk(0, 1, 5, 5, 1, 0, 0, 0, 0, 0, LU0), 1'b1, "lsbr_c0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FL1), 1'b1, "lsbr_c1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE), 1'b1, "lsbr_c2");
    step(mk(0, 1, 5, 5, 1, 0, 0, 0, 0, 0, LU0), 1'b1, "lsmw_c0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ST1), 1'b1, "lsmw_c1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ST2), 1'b1, "lsmw_c2");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RL2), 1'b1, "lsmw_c3");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LU1), 1'b1, "lsmw_c4");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LU1), 1'b1, "lsmw_c5");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE), 1'b1, "lsmw_c6");
    // timeout with MAX_WAIT=4, sticky ERR, then reset recovery
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE), 1'b0, "to_rst");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ST0), 1'b0, "to_c0");
    for (int i = 1; i <= 4; i++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ST2), 1'b0, $sformatf("to_c%0d", i));
    step(mk(0, 1, 5, 5, 1, 0, 0, 1, 1, 1, E3), 1'b0, "to_err0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E3), 1'b0, "to_err1");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE), 1'b0, "to_rst2");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE), 1'b0, "to_after");
    for (int i = 0; i < 800; i++) begin
      v = mk((i == 0) || ($urandom_range(0, 59) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, IDLE);
      @(posedge clk);
      #1 drive(v);
      @(negedge clk);
      model(0, v, ea);
      model(1, v, eb);
      chk($sformatf("rnd_a%0d", i), act_a, ea);
      chk($sformatf("rnd_b%0d", i), act_b, eb);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
